// File: rtl/core_conf_pkg.sv
// Shared types, bus widths and timer sizing for the pixel-core configuration sequencer.
package core_conf_pkg;

    localparam int CONF_ADDR_W = 12;
    localparam int CONF_DATA_W = 8;
    localparam int CONF_CNT_W  = 6;

    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_WR_CYC      = 2;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_RD_LAT      = 4;
    localparam int DEF_DEFCONF_CYC = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RDWAIT,
        DEFCONF
    } state_t;

    function automatic int max_cyc(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // The timer is loaded with (cycles - 1), so it only has to hold max - 1.
    function automatic int tmr_width(input int max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

    localparam int TMR_W_DEF = tmr_width(max_cyc(DEF_SETUP_CYC, DEF_WR_CYC, DEF_HOLD_CYC,
                                                 DEF_RD_LAT, DEF_DEFCONF_CYC));

endpackage

// File: rtl/core_conf_if.sv
// Request/read-return side from the command decoder plus the CoreCommonIf configuration bus.
interface core_conf_if;
    import core_conf_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_wr;
    logic [CONF_ADDR_W-1:0] req_addr;
    logic [CONF_DATA_W-1:0] req_data;
    logic [CONF_CNT_W-1:0]  req_cnt;
    logic                   def_conf_req;
    logic                   rd_valid;
    logic [CONF_DATA_W-1:0] rd_data;
    logic [CONF_ADDR_W-1:0] rd_addr;
    logic                   busy;
    logic [CONF_ADDR_W-1:0] AddressConfIn;
    logic [CONF_DATA_W-1:0] DataConfWrIn;
    logic                   ConfWrIn;
    logic [CONF_DATA_W-1:0] DataConfRdOut;
    logic                   DefConf;

    modport slave (
        input  req_valid, req_wr, req_addr, req_data, req_cnt, def_conf_req, DataConfRdOut,
        output req_ready, rd_valid, rd_data, rd_addr, busy,
               AddressConfIn, DataConfWrIn, ConfWrIn, DefConf
    );

    modport master (
        output req_valid, req_wr, req_addr, req_data, req_cnt, def_conf_req, DataConfRdOut,
        input  req_ready, rd_valid, rd_data, rd_addr, busy,
               AddressConfIn, DataConfWrIn, ConfWrIn, DefConf
    );

endinterface

// File: rtl/core_conf_timer.sv
// Loadable down-counter shared by every timed state; done is high while the count sits at zero.
module core_conf_timer #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/core_conf_ctrl.sv
// Pixel-core configuration sequencer: setup/strobe/hold write timing, timed reads, DefConf pulses.
//   state   | meaning
//   IDLE    | ready for a request or a DefConf request
//   SETUP   | address/data stable, strobe low
//   STROBE  | ConfWrIn high
//   HOLD    | address/data held after strobe
//   RDWAIT  | read latency, sample DataConfRdOut on last cycle
//   DEFCONF | DefConf pulse
module core_conf_ctrl
    import core_conf_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int WR_CYC      = DEF_WR_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int RD_LAT      = DEF_RD_LAT,
    parameter int DEFCONF_CYC = DEF_DEFCONF_CYC
) (
    input  logic       Clk,
    input  logic       Reset,
    core_conf_if.slave bus
);

    localparam int TMR_W = tmr_width(max_cyc(SETUP_CYC, WR_CYC, HOLD_CYC, RD_LAT, DEFCONF_CYC));

    state_t                 state, state_nxt;
    logic                   run_en;
    logic                   wr_op;
    logic [CONF_CNT_W-1:0]  cnt_rem;
    logic [CONF_ADDR_W-1:0] addr_q;
    logic [CONF_DATA_W-1:0] data_q;
    logic [CONF_DATA_W-1:0] rd_data_q;
    logic [CONF_ADDR_W-1:0] rd_addr_q;
    logic                   rd_valid_q;
    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_val;
    logic                   tmr_done;
    logic                   accept;
    logic                   advance;
    logic                   rd_cap;
    logic                   more;

    core_conf_timer #(.W(TMR_W)) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign more = (cnt_rem > CONF_CNT_W'(1));

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        accept    = 1'b0;
        advance   = 1'b0;
        rd_cap    = 1'b0;
        case (state)
            IDLE: begin
                if (run_en) begin
                    if (bus.def_conf_req) begin
                        state_nxt = DEFCONF;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(DEFCONF_CYC - 1);
                    end else if (bus.req_valid) begin
                        accept    = 1'b1;
                        state_nxt = SETUP;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    tmr_load  = 1'b1;
                    state_nxt = wr_op ? STROBE : RDWAIT;
                    tmr_val   = wr_op ? TMR_W'(WR_CYC - 1) : TMR_W'(RD_LAT - 1);
                end
            end
            STROBE: begin
                if (tmr_done) begin
                    state_nxt = HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(HOLD_CYC - 1);
                end
            end
            HOLD, RDWAIT: begin
                if (tmr_done) begin
                    rd_cap    = (state == RDWAIT);
                    advance   = more;
                    state_nxt = more ? SETUP : IDLE;
                    tmr_load  = more;
                    tmr_val   = TMR_W'(SETUP_CYC - 1);
                end
            end
            DEFCONF: begin
                if (tmr_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // run_en keeps req_ready low for the first cycle after a reset edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_en     <= 1'b0;
            wr_op      <= 1'b0;
            cnt_rem    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            run_en     <= 1'b1;
            rd_valid_q <= rd_cap;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wr_op   <= bus.req_wr;
                cnt_rem <= (bus.req_cnt == '0) ? CONF_CNT_W'(1) : bus.req_cnt;
                if (bus.req_wr) data_q <= bus.req_data;
            end
            if (rd_cap) begin
                rd_data_q <= bus.DataConfRdOut;
                rd_addr_q <= addr_q;
            end
            if (advance) begin
                addr_q  <= addr_q + CONF_ADDR_W'(1);
                cnt_rem <= cnt_rem - CONF_CNT_W'(1);
            end
        end
    end

    assign bus.req_ready     = (state == IDLE) && run_en;
    assign bus.busy          = (state != IDLE);
    assign bus.ConfWrIn      = (state == STROBE);
    assign bus.DefConf       = (state == DEFCONF);
    assign bus.AddressConfIn = addr_q;
    assign bus.DataConfWrIn  = data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_core_conf_ctrl.sv
// Self-checking bench for core_conf_ctrl: directed scenarios plus random bursts against a timing model.
`timescale 1ns/1ps
module tb_core_conf_ctrl;
    import core_conf_pkg::*;

    localparam int S = 2;
    localparam int W = 2;
    localparam int H = 1;
    localparam int R = 4;
    localparam int D = 16;

    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic Clk = 1'b0;
    logic Reset;
    core_conf_if bus();

    core_conf_ctrl #(
        .SETUP_CYC   (S),
        .WR_CYC      (W),
        .HOLD_CYC    (H),
        .RD_LAT      (R),
        .DEFCONF_CYC (D)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int         cyc = 0;
    int         n_vec = 0;
    int         miscompares = 0;
    logic [7:0] rd_key = 8'hFF;
    logic [11:0] model_addr = '0;
    logic [7:0]  model_wdata = '0;

    ev_t strobe_q[$];
    ev_t rdv_q[$];
    int  defconf_q[$];
    int  acc_q[$];

    // Core chain read model: data is a keyed function of the address presented.
    assign bus.DataConfRdOut = bus.AddressConfIn[7:0] ^ rd_key;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (bus.ConfWrIn === 1'b1) strobe_q.push_back({32'(cyc), bus.AddressConfIn, bus.DataConfWrIn});
        if (bus.rd_valid === 1'b1) rdv_q.push_back({32'(cyc), bus.rd_addr, bus.rd_data});
        if (bus.DefConf === 1'b1)  defconf_q.push_back(cyc);
        if (bus.req_valid && bus.req_ready === 1'b1 && !bus.def_conf_req) acc_q.push_back(cyc);
        if (bus.ConfWrIn === 1'b1 || bus.DefConf === 1'b1)
            check("strobe_defconf_excl", 64'(bus.ConfWrIn & bus.DefConf), 64'd0);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_q();
        strobe_q.delete();
        rdv_q.delete();
        defconf_q.delete();
        acc_q.delete();
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (bus.req_ready === 1'b1) ok = 1'b1;
            else tick();
        end
        check("ready_timeout", 64'(ok), 64'd1);
    endtask

    function automatic logic [44:0] all_outputs();
        return {bus.req_ready, bus.busy, bus.rd_valid, bus.ConfWrIn, bus.DefConf,
                bus.AddressConfIn, bus.DataConfWrIn, bus.rd_data, bus.rd_addr};
    endfunction

    // Expected timeline: each access is a fixed-length slot starting one cycle after acceptance.
    task automatic verify(input bit wr, input logic [11:0] addr, input logic [7:0] data,
                          input int cnt, input int t0, input int rdy);
        int   n;
        int   slot;
        ev_t  e;
        logic [11:0] a;
        n    = (cnt == 0) ? 1 : cnt;
        slot = wr ? (S + W + H) : (S + R);
        check("ready_cycle", 64'(rdy), 64'(1 + n * slot));
        check("strobe_count", 64'(strobe_q.size()), 64'(wr ? n * W : 0));
        check("rdv_count", 64'(rdv_q.size()), 64'(wr ? 0 : n));
        for (int i = 0; i < n; i++) begin
            a = addr + 12'(i);
            if (wr) begin
                for (int j = 0; j < W; j++) begin
                    if (i * W + j < strobe_q.size()) begin
                        e = {32'(t0 + 1 + i * slot + S + j), a, data};
                        check("strobe", 64'(strobe_q[i * W + j]), 64'(e));
                    end
                end
            end else if (i < rdv_q.size()) begin
                e = {32'(t0 + 1 + i * slot + S + R), a, a[7:0] ^ rd_key};
                check("rd_valid", 64'(rdv_q[i]), 64'(e));
            end
        end
        if (wr) model_wdata = data;
        model_addr = addr + 12'(n - 1);
        check("addr_hold", 64'(bus.AddressConfIn), 64'(model_addr));
        check("wdata_hold", 64'(bus.DataConfWrIn), 64'(model_wdata));
    endtask

    task automatic do_op(input bit wr, input logic [11:0] addr, input logic [7:0] data,
                         input logic [5:0] cnt, input bit hold);
        int t0;
        int rdy;
        clear_q();
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_cnt   = cnt;
        t0 = cyc;
        tick();
        if (!hold) bus.req_valid = 1'b0;
        check("addr_cycle1", 64'(bus.AddressConfIn), 64'(addr));
        check("busy_cycle1", 64'({bus.busy, bus.req_ready}), 64'(2'b10));
        wait_ready();
        rdy = cyc - t0;
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("accept_count", 64'(acc_q.size()), 64'd1);
        if (acc_q.size() > 0) check("accept_cycle", 64'(acc_q[0]), 64'(t0));
        verify(wr, addr, data, int'(cnt), t0, rdy);
    endtask

    initial begin
        int t0;
        int rdy;
        bus.req_valid    = 1'b0;
        bus.req_wr       = 1'b0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        bus.req_cnt      = '0;
        bus.def_conf_req = 1'b0;
        Reset = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 64'(all_outputs()), 64'd0);
        Reset = 1'b0;
        tick();
        check("ready_after_reset", 64'(bus.req_ready), 64'd1);

        do_op(1'b1, 12'h123, 8'hA5, 6'd1, 1'b0);
        do_op(1'b1, 12'hFFE, 8'h3C, 6'd3, 1'b0);
        rd_key = 8'hFF;
        do_op(1'b0, 12'h040, 8'h99, 6'd2, 1'b0);

        // DefConf and a write offered together: DefConf wins, the write waits.
        clear_q();
        bus.def_conf_req = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_wr       = 1'b1;
        bus.req_addr     = 12'h055;
        bus.req_data     = 8'h77;
        bus.req_cnt      = 6'd1;
        t0 = cyc;
        check("ready_with_defreq", 64'(bus.req_ready), 64'd1);
        tick();
        bus.def_conf_req = 1'b0;
        check("defconf_start", 64'({bus.DefConf, bus.req_ready, bus.AddressConfIn}),
              64'({1'b1, 1'b0, model_addr}));
        for (int i = 0; i < 100 && acc_q.size() == 0; i++) tick();
        bus.req_valid = 1'b0;
        wait_ready();
        rdy = cyc - (t0 + D + 1);
        tick();
        tick();
        check("defconf_len", 64'(defconf_q.size()), 64'(D));
        if (defconf_q.size() == D) begin
            check("defconf_first", 64'(defconf_q[0]), 64'(t0 + 1));
            check("defconf_last", 64'(defconf_q[D - 1]), 64'(t0 + D));
        end
        check("defconf_accept_count", 64'(acc_q.size()), 64'd1);
        if (acc_q.size() > 0) check("defconf_accept_cycle", 64'(acc_q[0]), 64'(t0 + D + 1));
        verify(1'b1, 12'h055, 8'h77, 1, t0 + D + 1, rdy);

        // Reset during the strobe of the second write of a burst.
        clear_q();
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 12'h200;
        bus.req_data  = 8'h5A;
        bus.req_cnt   = 6'd3;
        t0 = cyc;
        tick();
        bus.req_valid = 1'b0;
        while (cyc < t0 + 8) tick();
        check("strobe_before_rst", 64'(bus.ConfWrIn), 64'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_outputs", 64'(all_outputs()), 64'd0);
        tick();
        check("ready_after_rst", 64'(bus.req_ready), 64'd1);
        repeat (30) tick();
        check("strobes_after_rst", 64'(strobe_q.size()), 64'd3);
        check("rdv_after_rst", 64'(rdv_q.size()), 64'd0);
        model_addr  = '0;
        model_wdata = '0;

        // cnt=0 read with req_valid held high across the whole access.
        rd_key = 8'h3D;
        do_op(1'b0, 12'h7F0, 8'h11, 6'd0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            logic [11:0] ra;
            ra     = ($urandom_range(0, 2) == 0) ? 12'(12'hFFD + $urandom_range(0, 2)) : 12'($urandom);
            rd_key = 8'($urandom);
            do_op(1'($urandom_range(0, 1)), ra, 8'($urandom), 6'($urandom_range(0, 6)),
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule

// File: doc/core_conf_ctrl.md
Name: core_conf_ctrl

Overview:
- Sequencer for the pixel-core configuration bus of CoreCommonIf: AddressConfIn, DataConfWrIn, ConfWrIn, DataConfRdOut and DefConf.
- Takes single or auto-incrementing write/read requests from the global command decoder.
- Generates the setup / write-strobe / hold timing the core chain requires, returns read data, and issues timed DefConf pulses.
- Sits between the command decoder and the array's first CoreCommonIf port.

Parameters:
SETUP_CYC, 2, cycles address/data are stable before ConfWrIn rises or before the read wait starts (legal range >=1)
WR_CYC, 2, cycles ConfWrIn is held high per write (>=1)
HOLD_CYC, 1, cycles address/data are held after ConfWrIn falls (>=1)
RD_LAT, 4, cycles from end of SETUP to sampling DataConfRdOut (>=1)
DEFCONF_CYC, 16, length of the DefConf pulse (>=1)

Ports:
Clk  in  1  single system clock; all logic on rising edge
Reset  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  controller accepts a request this cycle
req_wr  in  1  1=write, 0=read
req_addr  in  12  start configuration address
req_data  in  8  write data; the same byte is used for every access of a burst
req_cnt  in  6  number of accesses; 0 is treated as 1
def_conf_req  in  1  request a DefConf pulse
rd_valid  out  1  one-cycle pulse; rd_data/rd_addr valid
rd_data  out  8  captured DataConfRdOut
rd_addr  out  12  address the rd_data belongs to
busy  out  1  high whenever state != IDLE
AddressConfIn  out  12  configuration address to the core chain
DataConfWrIn  out  8  configuration write data to the core chain
ConfWrIn  out  1  configuration write strobe
DataConfRdOut  in  8  configuration read data from the core chain
DefConf  out  1  load-default-configuration pulse

Behaviour:
- Reset (sync, high):
  - All outputs are 0 at the next edge: req_ready, busy, rd_valid, ConfWrIn, DefConf, AddressConfIn, DataConfWrIn, rd_data, rd_addr.
  - The FSM goes to IDLE, counters clear, and any in-flight operation is dropped without producing rd_valid.
  - req_ready rises on the first cycle after Reset deasserts.
- States: IDLE, SETUP, STROBE, HOLD, RDWAIT, DEFCONF.
- IDLE:
  - req_ready=1.
  - If def_conf_req=1, go to DEFCONF. DefConf has priority over req_valid in the same cycle; req_ready stays 1 that cycle but the request is NOT accepted, and req_ready is 0 from the next cycle.
  - Otherwise, on req_valid & req_ready, latch addr/data/wr/cnt (0 becomes 1), drive AddressConfIn=req_addr and DataConfWrIn=req_data (write only), and go to SETUP.
- SETUP: SETUP_CYC cycles with ConfWrIn=0. Then go to STROBE on a write, RDWAIT on a read.
- STROBE: ConfWrIn=1 for WR_CYC cycles, then HOLD.
- HOLD: ConfWrIn=0 for HOLD_CYC cycles. Then decrement the remaining count:
  - if nonzero, AddressConfIn += 1 (mod 4096; 0xFFF wraps to 0x000) and go to SETUP;
  - else go to IDLE.
- RDWAIT:
  - RD_LAT cycles.
  - On the last cycle, capture DataConfRdOut into rd_data and AddressConfIn into rd_addr; rd_valid=1 on the following cycle.
  - Then increment the address and go to SETUP, or go to IDLE as for HOLD. A read has no STROBE/HOLD.
- DEFCONF: DefConf=1 for exactly DEFCONF_CYC cycles, then IDLE. Address/data outputs are unchanged.
- Hold between operations: AddressConfIn and DataConfWrIn keep their last value in IDLE. DataConfWrIn is not modified by reads.
- Latency, defaults, accept at cycle 0:
  - Single write: ConfWrIn high in cycles 3–4; req_ready high again at cycle 6.
  - Single read: rd_valid at cycle 7 with data sampled at cycle 6; req_ready high at cycle 7.
- Burst of N writes: each write takes SETUP_CYC+WR_CYC+HOLD_CYC cycles, with no idle cycle between writes.
- ConfWrIn is never high during SETUP, HOLD, RDWAIT or DEFCONF. ConfWrIn and DefConf are never high together.
- Inputs are ignored while not in IDLE; a request is not queued.

Decomposition:
- Package core_conf_pkg:
  - state enum (IDLE..DEFCONF);
  - CONF_ADDR_W=12, CONF_DATA_W=8, CONF_CNT_W=6;
  - a timer width derived from the maximum parameter.
- Sub-module core_conf_timer: loadable down-counter with a done flag, shared by all timed states.
- The FSM, address incrementer and read-capture registers live in core_conf_ctrl.

Test Plan:
- Write 0x123 data 0xA5, cnt=1 → AddressConfIn=0x123 from cycle 1; ConfWrIn high exactly cycles 3–4; req_ready back at cycle 6; no rd_valid.
- Write burst addr 0xFFE, cnt=3, data 0x3C → three strobes at addresses 0xFFE, 0xFFF, 0x000, spaced 5 cycles apart; DataConfWrIn=0x3C throughout.
- Read 0x040, cnt=2, with a model returning addr[7:0]^0xFF → rd_valid pulses with (0x040, 0xBF) then (0x041, 0xBE); ConfWrIn stays 0.
- def_conf_req and req_valid in the same cycle → DefConf high 16 cycles; write request not accepted; the resubmitted write starts after DefConf ends.
- Reset asserted during STROBE of the second burst write → ConfWrIn=0 and all outputs 0 at the next edge; no further strobes; req_ready=1 the cycle after Reset falls.
- Read with cnt=0 → exactly one rd_valid; req_valid held high while busy produces no extra accesses.
